ofm_wr_sched: RTL
=================

Name: ofm_wr_sched

Overview:
- Write-master burst scheduler for the OFM output path.
- Takes one layer-level write job (base offset + byte size) and splits it into AXI-legal bursts.
- Bursts never cross a 4 KB boundary and never exceed BURST_LENGTH beats.
- Issues one wmst_req per burst only once the output FIFO holds enough 512-bit words; sits between the conv controller and the write master / output FIFO.

Parameters:
- DATA_WIDTH, 512, stream word width in bits; one beat = DATA_WIDTH/8 = 64 bytes.
- BURST_LENGTH, 64, maximum beats per burst (4096 bytes at default width).
- FIFO_ADDR_WIDTH, 7, output FIFO address bits; fifo_data_cnt is FIFO_ADDR_WIDTH+1 bits.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- op_start  in  1  one-cycle pulse; latches job, ignored unless IDLE
- wmst_offset  in  64  job byte address; bits [5:0] ignored (treated as 0)
- ofm_size  in  32  job byte count; rounded up to a multiple of 64
- fifo_data_cnt  in  FIFO_ADDR_WIDTH+1  words currently in the output FIFO
- end_conv  in  1  pulse; producer finished, FIFO contents are final
- wmst_req  out  1  one-cycle burst request
- wmst_addr  out  64  burst start address, valid while req and until done
- wmst_xfer_size  out  64  burst byte count, multiple of 64
- wmst_done  in  1  pulse; current burst complete
- busy  out  1  job in progress
- job_done  out  1  one-cycle pulse after last burst's wmst_done
- write_buffer_wait  out  1  high from job start until job_done

Behaviour:
- Reset: wmst_req=0, wmst_addr=0, wmst_xfer_size=0, busy=0, job_done=0, write_buffer_wait=0, FSM=IDLE, internal counters=0, end flag=0.
- Job latch in IDLE on op_start:
  - cur_addr <= {wmst_offset[63:6],6'b0}.
  - remaining <= (ofm_size+63) & ~63, computed in 33 bits.
  - end flag cleared; busy=1; write_buffer_wait=1 next cycle.
  - If the rounded size is 0: go directly to FINISH.
- FSM states: IDLE, CALC, WAIT_DATA, REQ, WAIT_DONE, FINISH.
- CALC (1 cycle): compute the next burst.
  - burst_bytes = min(remaining, BURST_LENGTH*64, 4096 - cur_addr[11:0]).
  - burst_words = burst_bytes/64.
  - Register burst_bytes into wmst_xfer_size and cur_addr into wmst_addr.
  - Go to WAIT_DATA.
- WAIT_DATA: stay until fifo_data_cnt >= burst_words OR the end flag is set, then go to REQ.
  - The end flag is set by end_conv in any non-IDLE state and is sticky until FINISH.
  - With the end flag set, the burst is issued even if the FIFO is short; the write master pads.
- REQ: wmst_req=1 for exactly one cycle, then go to WAIT_DONE.
- WAIT_DONE: on wmst_done, cur_addr += burst_bytes and remaining -= burst_bytes.
  - If the new remaining is 0, go to FINISH; otherwise go to CALC.
  - wmst_done in any other state is ignored.
- FINISH: job_done=1 for one cycle; busy and write_buffer_wait drop the same cycle; return to IDLE.
- Latency:
  - op_start to first wmst_req is at least 3 cycles (latch, CALC, WAIT_DATA with data present, REQ asserted on the 3rd edge).
  - wmst_done to next wmst_req is at least 3 cycles.
- Boundaries:
  - A burst ending exactly on a 4 KB boundary is legal.
  - The next burst starts at offset 0 of the following page.
  - cur_addr wraps modulo 2^64 without error.
- op_start while busy is ignored; the job is not restarted.
- end_conv in IDLE is ignored; end_conv together with op_start is captured.
- Reset mid-job aborts immediately to reset values. No partial job_done is issued.

Test Plan:
- Aligned single burst: offset 0x1000, size 4096, FIFO cnt 64 → one req with addr 0x1000, size 4096; done → job_done; write_buffer_wait high for the whole job.
- Page split: offset 0x1F80, size 256, FIFO full → req1 addr 0x1F80 size 128; req2 addr 0x2000 size 128; job_done after the second done.
- Max-length split: offset 0, size 10000 → size rounded to 10048; bursts 4096, 4096, 1856 at 0x0, 0x1000, 0x2000.
- Data gating: size 4096, FIFO cnt held at 63 → no req; cnt→64 gives req 3 cycles later. Repeat with cnt=10 and an end_conv pulse → req issued with size 4096.
- Protocol edges: op_start while busy ignored; stray wmst_done in WAIT_DATA ignored; size 0 → job_done pulse with no wmst_req.
- Reset mid-job: assert rst_n=0 in WAIT_DONE → all outputs 0 asynchronously; after release, a new op_start (offset 0x40, size 64) gives addr 0x40, size 64.

Source files
------------

// File: rtl/ofm_wr_sched.sv
// OFM write-burst scheduler: splits one layer write job into bursts
// that never cross a 4 KB page, gated on output FIFO fill level.
module ofm_wr_sched #(
   parameter int DATA_WIDTH      = 512,
   parameter int BURST_LENGTH    = 64,
   parameter int FIFO_ADDR_WIDTH = 7
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     op_start,
   input  logic [63:0]              wmst_offset,
   input  logic [31:0]              ofm_size,
   input  logic [FIFO_ADDR_WIDTH:0] fifo_data_cnt,
   input  logic                     end_conv,
   output logic                     wmst_req,
   output logic [63:0]              wmst_addr,
   output logic [63:0]              wmst_xfer_size,
   input  logic                     wmst_done,
   output logic                     busy,
   output logic                     job_done,
   output logic                     write_buffer_wait
);
   localparam int          BEAT_B  = DATA_WIDTH / 8;
   localparam int          BEAT_SH = $clog2(BEAT_B);
   localparam logic [63:0] BEAT_M  = 64'(BEAT_B - 1);
   localparam logic [32:0] BEAT_M33 = 33'(BEAT_B - 1);
   localparam logic [63:0] MAX_B   = 64'(BURST_LENGTH * BEAT_B);
   localparam logic [63:0] PAGE_B  = 64'd4096;

   typedef enum logic [2:0] {
      IDLE, CALC, WAIT_DATA, REQ, WAIT_DONE, FINISH
   } state_t;

   state_t      state_q, state_d;
   logic [63:0] cur_q, cur_d;
   logic [63:0] rem_q, rem_d;
   logic [63:0] addr_q, addr_d;
   logic [63:0] xfer_q, xfer_d;
   logic        end_q, end_d;

   logic [32:0] size_rnd;
   logic [63:0] room;
   logic [63:0] burst;
   logic [63:0] words;
   logic        have_data;

   always_comb begin
      size_rnd = ({1'b0, ofm_size} + BEAT_M33) & ~BEAT_M33;
      room     = PAGE_B - {52'd0, cur_q[11:0]};
      burst    = (rem_q < MAX_B) ? rem_q : MAX_B;
      if (room < burst) burst = room;
      words     = xfer_q >> BEAT_SH;
      have_data = {{(63 - FIFO_ADDR_WIDTH){1'b0}}, fifo_data_cnt} >= words;
   end

   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      rem_d   = rem_q;
      addr_d  = addr_q;
      xfer_d  = xfer_q;
      end_d   = end_q;
      unique case (state_q)
         IDLE: begin
            if (op_start) begin
               cur_d   = wmst_offset & ~BEAT_M;
               rem_d   = {31'd0, size_rnd};
               end_d   = end_conv;
               state_d = (size_rnd == 33'd0) ? FINISH : CALC;
            end
         end
         CALC: begin
            addr_d  = cur_q;
            xfer_d  = burst;
            state_d = WAIT_DATA;
         end
         WAIT_DATA: begin
            if (have_data || end_q) state_d = REQ;
         end
         REQ: state_d = WAIT_DONE;
         WAIT_DONE: begin
            if (wmst_done) begin
               cur_d   = cur_q + xfer_q;
               rem_d   = rem_q - xfer_q;
               state_d = (rem_q == xfer_q) ? FINISH : CALC;
            end
         end
         FINISH: begin
            end_d   = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // producer-finished flag is sticky for the rest of the job
      if (end_conv && state_q != IDLE && state_q != FINISH) end_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cur_q   <= '0;
         rem_q   <= '0;
         addr_q  <= '0;
         xfer_q  <= '0;
         end_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         rem_q   <= rem_d;
         addr_q  <= addr_d;
         xfer_q  <= xfer_d;
         end_q   <= end_d;
      end
   end

   assign wmst_req          = (state_q == REQ);
   assign wmst_addr         = addr_q;
   assign wmst_xfer_size    = xfer_q;
   assign job_done          = (state_q == FINISH);
   assign busy              = state_q inside {CALC, WAIT_DATA, REQ, WAIT_DONE};
   assign write_buffer_wait = busy;

endmodule
